pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline stage register with two-entry skid buffer
//
// Purpose:
//   Generic replacement for the fixed per-boundary pipeline registers. Holds up
//   to two entries (main = head, skid = second), so the stage keeps one
//   transfer per cycle while in_ready depends only on registered state and rst.
//   The control field reads CTRL_BUBBLE whenever the stage is empty.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall                hold the head entry (blocks drain only)
//   flush                drop all held entries and any same-cycle input
//   in_valid/in_ready    upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready  downstream handshake, out_data/out_ctrl head entry
//   count                occupancy 0..2
//   bubble_cnt           saturating count of cycles with out_valid = 0
//
// Build option:
//   PIPE_STAGE_FLUSH_ZERO_EN - data registers clear on flush and on the move to
//   empty, and out_data reads 0 whenever out_valid = 0.

module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;

    logic accept;
    logic drain;

    // The state encoding doubles as the occupancy count.
    assign count     = state_q;
    assign in_ready  = ~rst & (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);

    assign accept = in_valid & in_ready & ~flush;
    assign drain  = out_valid & out_ready & ~stall & ~flush;

    assign out_ctrl   = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign bubble_cnt = bubble_q;

`ifdef PIPE_STAGE_FLUSH_ZERO_EN
    assign out_data = out_valid ? main_data_q : '0;
`else
    assign out_data = main_data_q;
`endif

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        bubble_d    = bubble_q;

        if (!out_valid && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + 1'b1;
        end

        if (flush) begin
            state_d = ST_EMPTY;
`ifdef PIPE_STAGE_FLUSH_ZERO_EN
            main_data_d = '0;
            skid_data_d = '0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        // Downstream stopped: park the in-flight entry in skid.
                        state_d     = ST_FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (drain && !accept) begin
                        state_d = ST_EMPTY;
`ifdef PIPE_STAGE_FLUSH_ZERO_EN
                        main_data_d = '0;
                        skid_data_d = '0;
`endif
                    end else if (accept && drain) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid->main move can happen.
                    if (drain) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
            bubble_q    <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            bubble_q    <= bubble_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg

module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 16;
    localparam logic [CTRL_W-1:0] BUB = 16'hB0B0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst       = 1'b1;
    logic              stall     = 1'b0;
    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic [CTRL_W-1:0] in_ctrl   = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        count;
    logic [15:0]       bubble_cnt;

    logic              s_in_ready;
    logic              s_out_valid;
    logic [DATA_W-1:0] s_out_data;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [1:0]        s_count;
    logic [3:0]        s_bubble_cnt;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(BUB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .count(count), .bubble_cnt(bubble_cnt)
    );

    // Idle instance with a narrow counter to observe saturation.
    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(BUB), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0),
        .in_valid(1'b0), .in_ready(s_in_ready), .in_data('0), .in_ctrl('0),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .count(s_count), .bubble_cnt(s_bubble_cnt)
    );

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    ent_t model_q[$];   // entries the stage should hold
    ent_t exp_q[$];     // entries expected to leave at the next handshake
    int   checks = 0;
    int   errors = 0;
    int   bub    = 0;
    int   bub_s  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check state left by the previous edge, drive inputs, advance the model.
    task automatic cycle(input logic r, input logic iv, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input logic ordy, input logic st,
                         input logic fl);
        int n;
        @(negedge clk);
        n = model_q.size();
        chk("count", 64'(count), 64'(n));
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        chk("in_ready", 64'(in_ready), 64'(!rst && n != 2));
        if (n != 0) begin
            chk("out_data", out_data, model_q[0].d);
            chk("out_ctrl", 64'(out_ctrl), 64'(model_q[0].c));
        end else begin
            chk("out_ctrl_bubble", 64'(out_ctrl), 64'(BUB));
`ifdef PIPE_STAGE_FLUSH_ZERO_EN
            chk("out_data_zero", out_data, 64'd0);
`endif
        end
        chk("bubble_cnt", 64'(bubble_cnt), 64'(bub));
        chk("bubble_cnt_sat", 64'(s_bubble_cnt), 64'(bub_s));

        rst = r; in_valid = iv; in_data = d; in_ctrl = c;
        out_ready = ordy; stall = st; flush = fl;

        if (r) begin
            model_q.delete();
            bub   = 0;
            bub_s = 0;
        end else begin
            if (n == 0 && bub < 65535) bub++;
            if (bub_s < 15) bub_s++;
            if (fl) begin
                model_q.delete();
            end else begin
                if (n != 0 && ordy && !st) exp_q.push_back(model_q.pop_front());
                if (iv && n != 2) model_q.push_back('{d: d, c: c});
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a completed handshake.
    ent_t e;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst && out_valid && out_ready && !stall && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drain_unexpected: got data %h expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("drain_data", out_data, e.d);
                    chk("drain_ctrl", 64'(out_ctrl), 64'(e.c));
                end
            end
        end
    end

    initial begin
        // Reset held 3 cycles with in_valid asserted.
        repeat (3) cycle(1, 1, 64'h99, 16'h9, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Streaming.
        cycle(0, 1, 64'h11, 16'h1, 1, 0, 0);
        cycle(0, 1, 64'h22, 16'h2, 1, 0, 0);
        cycle(0, 1, 64'h33, 16'h3, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Backpressure: 0xC stays offered until accepted.
        cycle(0, 1, 64'hA, 16'hA, 0, 0, 0);
        cycle(0, 1, 64'hB, 16'hB, 0, 0, 0);
        cycle(0, 1, 64'hC, 16'hC, 0, 0, 0);
        cycle(0, 1, 64'hC, 16'hC, 0, 0, 0);
        cycle(0, 1, 64'hC, 16'hC, 1, 0, 0);
        cycle(0, 1, 64'hC, 16'hC, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Stall with head 0x5.
        cycle(0, 1, 64'h5, 16'h5, 1, 0, 0);
        cycle(0, 1, 64'h6, 16'h6, 1, 1, 0);
        cycle(0, 1, 64'h7, 16'h7, 1, 1, 0);
        cycle(0, 1, 64'h7, 16'h7, 1, 1, 0);
        cycle(0, 1, 64'h7, 16'h7, 1, 1, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Flush while FULL with in_valid and stall.
        cycle(0, 1, 64'hD1, 16'hD1, 0, 0, 0);
        cycle(0, 1, 64'hD2, 16'hD2, 0, 0, 0);
        cycle(0, 1, 64'hD3, 16'hD3, 1, 1, 1);
        cycle(0, 1, 64'hD4, 16'hD4, 1, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Randomized traffic with occasional stall, flush and reset.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 59) == 0,
                  ($urandom % 4) != 0,
                  {$urandom, $urandom},
                  16'($urandom),
                  ($urandom % 4) != 0,
                  ($urandom % 6) == 0,
                  ($urandom % 20) == 0);
        end

        // Drain and idle long enough to saturate the narrow counter.
        repeat (24) cycle(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #6;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
